// File: rtl/add_some_bitz_pkg.sv
// -----------------------------------------------------------------------------
// add_some_bitz_pkg
// Shared definitions for the add_some_bitz engine: register word offsets,
// CTRL bit positions, AXI response codes, the engine state enum and a
// byte-lane merge helper for strobed register writes.
// -----------------------------------------------------------------------------
package add_some_bitz_pkg;

  localparam int DATA_W = 32;

  // Word offsets (byte address bits [3:2]).
  localparam logic [1:0] REG_OPA    = 2'd0;
  localparam logic [1:0] REG_OPB    = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RESULT = 2'd3;

  // CTRL register bit positions.
  localparam int CTRL_START = 0;
  localparam int CTRL_BUSY  = 1;
  localparam int CTRL_DONE  = 2;

  // AXI response codes.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // One RUN cycle per operand bit.
  localparam logic [4:0] LAST_RUN_CNT = 5'd31;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } engine_state_e;

  // Replace only the byte lanes selected by strb.
  function automatic logic [DATA_W-1:0] apply_wstrb(
    input logic [DATA_W-1:0]   old_val,
    input logic [DATA_W-1:0]   new_val,
    input logic [DATA_W/8-1:0] strb
  );
    logic [DATA_W-1:0] merged;
    merged = old_val;
    for (int b = 0; b < DATA_W / 8; b++) begin
      if (strb[b]) merged[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/add_some_bitz_popcnt_core.sv
// -----------------------------------------------------------------------------
// add_some_bitz_popcnt_core
// Serial engine computing result = opb + popcount(opa) (mod 2^32).
// On start (ignored while running) it loads acc=opb, sh=opa and runs exactly
// 32 cycles, adding the LSB of sh each cycle; the last cycle writes result and
// sets done. done is cleared by start or by done_clr.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            one-cycle start request
//   done_clr         one-cycle clear request for done
//   opa, opb         operands, sampled on an accepted start
//   busy             engine is in RUN
//   done             sticky completion flag
//   result           last completed result (untouched by an aborted run)
// -----------------------------------------------------------------------------
module add_some_bitz_popcnt_core
  import add_some_bitz_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              done_clr,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  engine_state_e     state;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] sh;
  logic [4:0]        cnt;
  logic [DATA_W-1:0] acc_next;

  assign acc_next = acc + {{(DATA_W-1){1'b0}}, sh[0]};
  assign busy     = (state == S_RUN);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      acc    <= '0;
      sh     <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            // A start in the same write as a DONE clear still starts; the
            // load clears done either way.
            state <= S_RUN;
            acc   <= opb;
            sh    <= opa;
            cnt   <= '0;
            done  <= 1'b0;
          end else if (done_clr) begin
            done <= 1'b0;
          end
        end
        S_RUN: begin
          acc <= acc_next;
          sh  <= sh >> 1;
          cnt <= cnt + 5'd1;
          if (cnt == LAST_RUN_CNT) begin
            // The final bit is folded in here so result lands on the 32nd edge.
            result <= acc_next;
            done   <= 1'b1;
            state  <= S_IDLE;
          end else if (done_clr) begin
            done <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/add_some_bitz_engine.sv
// -----------------------------------------------------------------------------
// add_some_bitz_engine
// AXI4-Lite slave front end for the popcount-add engine.
// Register map (word = ADDR[3:2]):
//   0x0 OPA    RW (byte strobes honoured; SLVERR and dropped while busy)
//   0x4 OPB    RW (same rules as OPA)
//   0x8 CTRL   bit0 START (write 1, reads 0), bit1 BUSY RO, bit2 DONE RO/W1C
//   0xC RESULT RO (writes ignored, OKAY)
//
// Ports:
//   ACLK, ARESETN                 clock, asynchronous active-low reset
//   S_AXI_AW*/W*/B*               write address/data/response channels
//   S_AXI_AR*/R*                  read address/data channels
//   irq                           completion interrupt (= DONE), present only
//                                 when ADD_SOME_BITZ_IRQ_EN is defined
//
// Configuration macro: ADD_SOME_BITZ_IRQ_EN
// Only a 32-bit data width and 4-bit address width are supported.
// -----------------------------------------------------------------------------
module add_some_bitz_engine
  import add_some_bitz_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
`ifdef ADD_SOME_BITZ_IRQ_EN
  output logic                            irq,
`endif
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] result;
  logic              busy;
  logic              done;

  logic              wr_fire;
  logic              rd_fire;
  logic [1:0]        wr_idx;
  logic [1:0]        rd_idx;
  logic              wr_is_operand;
  logic [1:0]        wr_resp;
  logic              start;
  logic              done_clr;
  logic [DATA_W-1:0] rd_data;

  // Byte-offset bits are irrelevant for a word-only register file.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Ready flags are single-cycle pulses, so the beat lands while they are high.
  assign wr_fire = S_AXI_AWREADY & S_AXI_AWVALID & S_AXI_WREADY & S_AXI_WVALID;
  assign rd_fire = S_AXI_ARREADY & S_AXI_ARVALID;
  assign wr_idx  = S_AXI_AWADDR[3:2];
  assign rd_idx  = S_AXI_ARADDR[3:2];

  assign wr_is_operand = (wr_idx == REG_OPA) || (wr_idx == REG_OPB);
  assign wr_resp       = (wr_is_operand && busy) ? RESP_SLVERR : RESP_OKAY;

  assign start    = wr_fire && (wr_idx == REG_CTRL) && S_AXI_WSTRB[0]
                    && S_AXI_WDATA[CTRL_START];
  assign done_clr = wr_fire && (wr_idx == REG_CTRL) && S_AXI_WSTRB[0]
                    && S_AXI_WDATA[CTRL_DONE];

  // Write channel and operand registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      opa           <= '0;
      opb           <= '0;
    end else begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      if (!S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID) begin
        S_AXI_AWREADY <= 1'b1;
        S_AXI_WREADY  <= 1'b1;
      end

      if (wr_fire) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_resp;
        if (!busy) begin
          if (wr_idx == REG_OPA) opa <= apply_wstrb(opa, S_AXI_WDATA, S_AXI_WSTRB);
          if (wr_idx == REG_OPB) opb <= apply_wstrb(opb, S_AXI_WDATA, S_AXI_WSTRB);
        end
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  // Read mux.
  always_comb begin
    // NOTE: default first, so no path through the case leaves rd_data
    // unassigned and no latch is inferred.
    rd_data = '0;
    case (rd_idx)
      REG_OPA:    rd_data = opa;
      REG_OPB:    rd_data = opb;
      REG_CTRL: begin
        rd_data[CTRL_BUSY] = busy;
        rd_data[CTRL_DONE] = done;
      end
      REG_RESULT: rd_data = result;
      default:    rd_data = '0;
    endcase
  end

  // Read channel.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_RDATA   <= '0;
    end else begin
      S_AXI_ARREADY <= 1'b0;
      if (!S_AXI_ARREADY && S_AXI_ARVALID && !S_AXI_RVALID) S_AXI_ARREADY <= 1'b1;

      if (rd_fire) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RRESP  <= RESP_OKAY;
        S_AXI_RDATA  <= rd_data;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  add_some_bitz_popcnt_core u_core (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .start    (start),
    .done_clr (done_clr),
    .opa      (opa),
    .opb      (opb),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

`ifdef ADD_SOME_BITZ_IRQ_EN
  // done is itself a register, so irq is registered and follows its set/clear.
  assign irq = done;
`endif

endmodule
